// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the SPI CPU fetch/sequence stage: opcode map,
// execute-strobe bit positions and the sequencer state encoding.
package program_sequencer_pkg;

    // Four-bit opcode map shared by the ROM image, the sequencer and the datapath
    localparam logic [3:0] OP_LDA  = 4'd0;
    localparam logic [3:0] OP_LDB  = 4'd1;
    localparam logic [3:0] OP_LDO  = 4'd2;
    localparam logic [3:0] OP_LDSA = 4'd3;
    localparam logic [3:0] OP_LDSB = 4'd4;
    localparam logic [3:0] OP_LSH  = 4'd5;
    localparam logic [3:0] OP_RSH  = 4'd6;
    localparam logic [3:0] OP_CLR  = 4'd7;
    localparam logic [3:0] OP_SNZA = 4'd8;
    localparam logic [3:0] OP_SNZS = 4'd9;

    // Bit positions inside the strobe vector; they equal the opcode value
    localparam int STB_LDA  = 0;
    localparam int STB_LDB  = 1;
    localparam int STB_LDO  = 2;
    localparam int STB_LDSA = 3;
    localparam int STB_LDSB = 4;
    localparam int STB_LSH  = 5;
    localparam int STB_RSH  = 6;
    localparam int STB_CLR  = 7;
    localparam int STB_W    = 8;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    // One-hot strobe for a datapath opcode; SNZ and NOP opcodes give no strobe
    function automatic logic [STB_W-1:0] op_strobe(input logic [3:0] op);
        logic [STB_W-1:0] v;
        v = {STB_W{1'b0}};
        if (op[3] == 1'b0) begin
            v[op[2:0]] = 1'b1;
        end else begin
            v = {STB_W{1'b0}};
        end
        return v;
    endfunction

endpackage

// File: rtl/program_sequencer_opcode_decoder.sv
// Combinational opcode decoder: turns the instruction register contents into
// one-hot datapath strobes plus the two skip-next qualifiers.
module opcode_decoder
    import program_sequencer_pkg::*;
(
    input  logic [3:0]       opcode,
    input  logic             en,
    output logic [STB_W-1:0] strobe,
    output logic             is_snz_a,
    output logic             is_snz_s
);

    // Decode the opcode; everything stays low when the instruction is not issued
    always_comb begin
        strobe   = {STB_W{1'b0}};
        is_snz_a = 1'b0;
        is_snz_s = 1'b0;
        if (en) begin
            case (opcode)
                OP_LDA, OP_LDB, OP_LDO, OP_LDSA,
                OP_LDSB, OP_LSH, OP_RSH, OP_CLR: strobe = op_strobe(opcode);
                OP_SNZA: is_snz_a = 1'b1;
                OP_SNZS: is_snz_s = 1'b1;
                default: strobe = {STB_W{1'b0}};
            endcase
        end else begin
            strobe   = {STB_W{1'b0}};
            is_snz_a = 1'b0;
            is_snz_s = 1'b0;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Fetch/sequence stage of the SPI CPU. Presents the PC to a combinational
// ROM, latches the opcode into the IR, and issues one-hot execute strobes
// with SNZ skip-next, stall freeze, run/abort and end-of-program wrap/halt.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int PROG_LEN    = 32,
    parameter int HALT_AT_END = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  stall,
    input  logic                  zeroA,
    input  logic                  zeroS,
    input  logic [3:0]            romData,
    output logic [ADDR_WIDTH-1:0] romAddr,
    output logic                  opValid,
    output logic                  ldA,
    output logic                  ldB,
    output logic                  ldO,
    output logic                  ldSA,
    output logic                  ldSB,
    output logic                  lsh,
    output logic                  rsh,
    output logic                  clr,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PROG_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic                  HALT_EN   = (HALT_AT_END != 0);

    seq_state_t              state_r;
    logic [ADDR_WIDTH-1:0]   pc_r;
    logic [3:0]              ir_r;
    logic                    squash_r;

    logic [ADDR_WIDTH-1:0]   pc_next_s;
    logic                    op_valid_s;
    logic [STB_W-1:0]        strobe_s;
    logic                    is_snz_a_s;
    logic                    is_snz_s_s;
    logic                    skip_cond_s;
    logic                    ir_is_last_s;

    // Next fetch address with wrap at the end of the program
    always_comb begin
        if (pc_r == LAST_ADDR) begin
            pc_next_s = ZERO_ADDR;
        end else begin
            pc_next_s = pc_r + ONE_ADDR;
        end
    end

    // Issue qualifier: only registered state and stall gate the strobes
    always_comb begin
        op_valid_s = (state_r == ST_EXEC) & ~stall & ~squash_r;
    end

    opcode_decoder u_decoder (
        .opcode   (ir_r),
        .en       (op_valid_s),
        .strobe   (strobe_s),
        .is_snz_a (is_snz_a_s),
        .is_snz_s (is_snz_s_s)
    );

    // Skip-next condition; the decoder is enabled only for an unsquashed
    // issue, so a squashed SNZ can never chain a second skip
    always_comb begin
        skip_cond_s = (is_snz_a_s & ~zeroA) | (is_snz_s_s & ~zeroS);
    end

    // In EXEC the PC points one past the IR, so PC==0 means the IR holds
    // the final program word (this also covers a one-word program)
    always_comb begin
        ir_is_last_s = HALT_EN & (pc_r == ZERO_ADDR);
    end

    // Sequencer FSM with PC, IR and squash registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            pc_r     <= ZERO_ADDR;
            ir_r     <= OP_CLR;
            squash_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pc_r     <= ZERO_ADDR;
                    squash_r <= 1'b0;
                    if (run) begin
                        state_r <= ST_FILL;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (!run) begin
                        state_r  <= ST_IDLE;
                        pc_r     <= ZERO_ADDR;
                        squash_r <= 1'b0;
                    end else begin
                        state_r  <= ST_EXEC;
                        ir_r     <= romData;
                        pc_r     <= pc_next_s;
                        squash_r <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    if (!run) begin
                        state_r  <= ST_IDLE;
                        pc_r     <= ZERO_ADDR;
                        squash_r <= 1'b0;
                    end else if (stall) begin
                        state_r  <= ST_EXEC;
                        pc_r     <= pc_r;
                        ir_r     <= ir_r;
                        squash_r <= squash_r;
                    end else if (ir_is_last_s) begin
                        state_r  <= ST_DONE;
                        pc_r     <= ZERO_ADDR;
                        squash_r <= 1'b0;
                    end else begin
                        state_r  <= ST_EXEC;
                        ir_r     <= romData;
                        pc_r     <= pc_next_s;
                        squash_r <= skip_cond_s;
                    end
                end
                ST_DONE: begin
                    pc_r     <= ZERO_ADDR;
                    squash_r <= 1'b0;
                    if (!run) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    pc_r     <= ZERO_ADDR;
                    ir_r     <= OP_CLR;
                    squash_r <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping from registered state
    always_comb begin
        romAddr = pc_r;
        opValid = op_valid_s;
        ldA     = strobe_s[STB_LDA];
        ldB     = strobe_s[STB_LDB];
        ldO     = strobe_s[STB_LDO];
        ldSA    = strobe_s[STB_LDSA];
        ldSB    = strobe_s[STB_LDSB];
        lsh     = strobe_s[STB_LSH];
        rsh     = strobe_s[STB_RSH];
        clr     = strobe_s[STB_CLR];
        done    = (state_r == ST_DONE);
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Randomized and directed bench for program_sequencer. Two instances share
// stimulus: one wraps forever, one halts at the end of the program. Each is
// compared every cycle against a word-level model of the sequencing rules.
module tb_program_sequencer;

    localparam int L = 32;

    logic       clk;
    logic       rst_n;
    logic       run, stall, zeroA, zeroS;
    logic [3:0] rom [0:255];

    logic [7:0] addr0, addr1;
    logic [3:0] data0, data1;
    logic       opv0, ldA0, ldB0, ldO0, ldSA0, ldSB0, lsh0, rsh0, clr0, done0;
    logic       opv1, ldA1, ldB1, ldO1, ldSA1, ldSB1, lsh1, rsh1, clr1, done1;

    assign data0 = rom[addr0];
    assign data1 = rom[addr1];

    program_sequencer #(.ADDR_WIDTH(8), .PROG_LEN(L), .HALT_AT_END(0)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .stall(stall), .zeroA(zeroA), .zeroS(zeroS),
        .romData(data0), .romAddr(addr0), .opValid(opv0),
        .ldA(ldA0), .ldB(ldB0), .ldO(ldO0), .ldSA(ldSA0), .ldSB(ldSB0),
        .lsh(lsh0), .rsh(rsh0), .clr(clr0), .done(done0)
    );

    program_sequencer #(.ADDR_WIDTH(8), .PROG_LEN(L), .HALT_AT_END(1)) dut_h (
        .clk(clk), .rst_n(rst_n), .run(run), .stall(stall), .zeroA(zeroA), .zeroS(zeroS),
        .romData(data1), .romAddr(addr1), .opValid(opv1),
        .ldA(ldA1), .ldB(ldB1), .ldO(ldO1), .ldSA(ldSA1), .ldSB(ldSB1),
        .lsh(lsh1), .rsh(rsh1), .clr(clr1), .done(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Word-level model: which program word is in execution, whether it is skipped
    bit m_act [2];
    bit m_fill[2];
    bit m_halt[2];
    bit m_skip[2];
    int m_ea  [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_fill[k] = 0; m_halt[k] = 0; m_skip[k] = 0; m_ea[k] = 0;
        end
    endtask

    function automatic logic [31:0] exp_addr(int k);
        if (m_act[k]) return 32'((m_ea[k] + 1) % L);
        return 32'd0;
    endfunction

    function automatic logic [31:0] exp_vec(int k);
        logic [31:0] v;
        logic [3:0]  op;
        op = rom[m_ea[k]];
        v  = 32'd0;
        if (m_halt[k]) v[9] = 1'b1;
        if (m_act[k] && !stall && !m_skip[k]) begin
            v[8] = 1'b1;
            if (op < 4'd8) v[op] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_update(int k);
        logic [3:0] op;
        bit ns;
        if (!run) begin
            m_act[k] = 0; m_fill[k] = 0; m_halt[k] = 0; m_skip[k] = 0;
        end else if (m_halt[k]) begin
            m_halt[k] = 1;
        end else if (m_fill[k]) begin
            m_fill[k] = 0; m_act[k] = 1; m_ea[k] = 0; m_skip[k] = 0;
        end else if (m_act[k]) begin
            if (!stall) begin
                op = rom[m_ea[k]];
                ns = !m_skip[k] && ((op == 4'd8 && !zeroA) || (op == 4'd9 && !zeroS));
                if (k == 1 && m_ea[k] == L - 1) begin
                    m_act[k] = 0; m_halt[k] = 1; m_skip[k] = 0;
                end else begin
                    m_ea[k] = (m_ea[k] + 1) % L; m_skip[k] = ns;
                end
            end
        end else begin
            m_fill[k] = 1;
        end
    endtask

    function automatic logic [31:0] vec0();
        return {22'd0, done0, opv0, clr0, rsh0, lsh0, ldSB0, ldSA0, ldO0, ldB0, ldA0};
    endfunction

    function automatic logic [31:0] vec1();
        return {22'd0, done1, opv1, clr1, rsh1, lsh1, ldSB1, ldSA1, ldO1, ldB1, ldA1};
    endfunction

    logic [31:0] obs_vec0 [64];
    logic [31:0] obs_addr0[64];
    logic        obs_done1[64];
    int cyc = 0;

    // One clock: compare against the model, then advance model with sampled inputs
    task automatic cycle();
        #1;
        check_eq("addr_wrap", 32'(addr0), exp_addr(0));
        check_eq("out_wrap",  vec0(),     exp_vec(0));
        check_eq("addr_halt", 32'(addr1), exp_addr(1));
        check_eq("out_halt",  vec1(),     exp_vec(1));
        if (cyc < 64) begin
            obs_vec0[cyc]  = vec0();
            obs_addr0[cyc] = 32'(addr0);
            obs_done1[cyc] = done1;
        end
        @(posedge clk);
        model_update(0);
        model_update(1);
        @(negedge clk);
        cyc++;
    endtask

    // Asynchronous reset pulse; outputs must clear without waiting for a clock
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_eq(tag, {addr0, addr1, 16'd0}, 32'd0);
        check_eq(tag, vec0() | vec1(), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    int lsh_cnt;

    initial begin
        run = 1'b0; stall = 1'b0; zeroA = 1'b1; zeroS = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = 4'(i % 16);
        rom[0] = 4'd0; rom[1] = 4'd1; rom[2] = 4'd4; rom[3] = 4'd6;
        rom[4] = 4'd8; rom[5] = 4'd6; rom[6] = 4'd3; rom[7] = 4'd5;
        rom[8] = 4'd15; rom[9] = 4'd9;
        model_reset();
        #2;
        do_reset("reset_state");

        // Basic sequencing, SNZ not taken, stall over LSH, NOP
        run = 1'b1;
        for (int c = 0; c < 15; c++) begin
            stall = (c >= 9 && c <= 11);
            cycle();
        end
        stall = 1'b0;
        check_eq("first_ldA_c2", obs_vec0[2], 32'h101);
        check_eq("ldB_c3",       obs_vec0[3], 32'h102);
        check_eq("ldSB_c4",      obs_vec0[4], 32'h110);
        check_eq("rsh_c5",       obs_vec0[5], 32'h140);
        check_eq("snz_nottaken", obs_vec0[7], 32'h140);
        check_eq("stall_addr",   obs_addr0[11], 32'd8);
        check_eq("stall_quiet",  obs_vec0[10], 32'h000);
        check_eq("lsh_release",  obs_vec0[12], 32'h120);
        check_eq("nop_1111",     obs_vec0[13], 32'h100);
        lsh_cnt = 0;
        for (int c = 0; c < 15; c++) lsh_cnt += int'(obs_vec0[c][5]);
        check_eq("lsh_once", 32'(lsh_cnt), 32'd1);

        // SNZ A taken: RSH at addr 5 squashed, LDSA at addr 6 executes
        run = 1'b0; cycle();
        zeroA = 1'b0; run = 1'b1; cyc = 0;
        for (int c = 0; c < 9; c++) cycle();
        check_eq("squashed_rsh", obs_vec0[7], 32'h000);
        check_eq("after_squash", obs_vec0[8], 32'h108);

        // Reset while the squashed word is pending, then a clean restart
        run = 1'b0; cycle();
        run = 1'b1; cyc = 0;
        for (int c = 0; c < 7; c++) cycle();
        do_reset("reset_mid_squash");
        for (int c = 0; c < 4; c++) cycle();
        check_eq("restart_ldA", obs_vec0[2], 32'h101);

        // Wrap/halt at end of program, then abort at addr 10
        run = 1'b0; zeroA = 1'b1; cycle();
        run = 1'b1; cyc = 0;
        for (int c = 0; c < 46; c++) begin
            run = (c < 44) || (c == 44 && 1'b0);
            if (c == 44) run = 1'b0;
            else if (c < 44) run = 1'b1;
            cycle();
        end
        check_eq("done_after_last", 32'(obs_done1[34]), 32'd1);
        check_eq("wrap_addr",       obs_addr0[34], 32'd1);
        check_eq("wrap_ldA",        obs_vec0[34], 32'h101);
        check_eq("abort_unmasked",  obs_vec0[44], 32'h100);
        check_eq("abort_addr0",     obs_addr0[45], 32'd0);
        check_eq("abort_quiet",     obs_vec0[45], 32'h000);
        check_eq("done_cleared",    32'(obs_done1[45]), 32'd0);

        // Randomized programs and control
        for (int seg = 0; seg < 30; seg++) begin
            run = 1'b0; stall = 1'b0;
            cycle();
            for (int i = 0; i < L; i++) begin
                if ($urandom_range(0, 3) == 0) rom[i] = 4'(8 + $urandom_range(0, 1));
                else rom[i] = 4'($urandom_range(0, 15));
            end
            for (int c = 0; c < 80; c++) begin
                run   = ($urandom_range(0, 39) != 0);
                stall = ($urandom_range(0, 3) == 0);
                zeroA = 1'($urandom_range(0, 1));
                zeroS = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 149) == 0) do_reset("reset_random");
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
